// File: rtl/csa_mult_seq.sv
// ---------------------------------------------------------------------------
// csa_mult_seq
//   Sequential unsigned multiplier. Each ACCUM cycle adds one shifted partial
//   product into a redundant sum/carry pair through a 20-bit carry-save adder.
//   No carry ripples during accumulation. A single carry-propagate add in the
//   RESOLVE cycle turns the redundant pair into the binary product.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    operation request, sampled only in IDLE
//   a, b     W-bit unsigned operands, captured when start is accepted
//   busy     high while in ACCUM or RESOLVE
//   done     one-cycle pulse when product becomes valid
//   product  PW-bit result, held until the next RESOLVE
// ---------------------------------------------------------------------------
module csa_mult_seq #(
    parameter  int W  = 10,      // operand width, 2..10
    localparam int PW = 2 * W    // product width
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] product
);

    localparam int CSA_W = 20;
    localparam int CW    = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [W-1:0]      ra_q,      ra_d;
    logic [W-1:0]      rb_q,      rb_d;
    logic [CSA_W-1:0]  s_q,       s_d;
    logic [CSA_W-1:0]  c_q,       c_d;
    logic [CW-1:0]     count_q,   count_d;
    logic [PW-1:0]     product_q, product_d;
    logic              done_q,    done_d;

    // Datapath signals.
    logic [W-1:0]      pp_bits;
    logic [CSA_W-1:0]  pp;
    logic [CSA_W-1:0]  c_weighted;
    logic [CSA_W-1:0]  csa_sum;
    logic [CSA_W-1:0]  csa_cout;
    logic [CSA_W-1:0]  resolved;

    // C is stored unshifted; its doubled weight is applied wherever it is
    // consumed. Bits pushed out of bit 19 are always zero for W <= 10.
    assign c_weighted = c_q << 1;

    assign pp_bits = ra_q & {W{rb_q[count_q]}};
    assign pp      = CSA_W'(pp_bits) << count_q;

    // 3:2 compressor: S + 2C + pp == csa_sum + 2*csa_cout.
    assign csa_sum  = s_q ^ c_weighted ^ pp;
    assign csa_cout = (s_q & c_weighted) | (s_q & pp) | (c_weighted & pp);

    // The only carry-propagate add in the design, used once per operation.
    assign resolved = s_q + c_weighted;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        s_d       = s_q;
        c_d       = c_q;
        count_d   = count_q;
        product_d = product_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    s_d     = '0;
                    c_d     = '0;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                s_d     = csa_sum;
                c_d     = csa_cout;
                count_d = count_q + CW'(1);
                if (count_q == CW'(W - 1)) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                product_d = resolved[PW-1:0];
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    // All registers, including the datapath, reset so no X reaches product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ra_q      <= '0;
            rb_q      <= '0;
            s_q       <= '0;
            c_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            s_q       <= s_d;
            c_q       <= c_d;
            count_q   <= count_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_csa_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_csa_mult_seq
//   Self-checking bench for csa_mult_seq (W = 10). Directed stimulus pushes
//   the expected product and the accepting edge number into a scoreboard; a
//   monitor pops an entry on every done pulse and checks product, latency and
//   the number of busy cycles.
// ---------------------------------------------------------------------------
module tb_csa_mult_seq;

    localparam int W  = 10;
    localparam int PW = 2 * W;

    typedef struct {
        logic [PW-1:0] prod;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    int   cyc;
    int   busy_cnt;

    csa_mult_seq #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                check("busy_cycles", busy_cnt, W + 1);
                busy_cnt = 0;
                check("done_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", product, e.prod);
                    check("latency", cyc - e.cyc, W + 1);
                end
            end
        end
    end

    // Issue one operation from IDLE; returns #1 after the accepting edge.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{prod: PW'(ta) * PW'(tb_v), cyc: cyc});
        start = 1'b0;
    endtask

    // Wait until the scoreboard is empty and the DUT is idle, bounded.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 200), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        busy_cnt    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        a           = '0;
        b           = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 5 x 3.
        do_op(10'd5, 10'd3);
        drain("drain_5x3");
        check("product_hold", product, 15);

        // Maximum operands.
        do_op(10'h3FF, 10'h3FF);
        drain("drain_max");

        // Zero operands on either side.
        do_op(10'd0, 10'h2AB);
        drain("drain_zero_a");
        do_op(10'h155, 10'd0);
        drain("drain_zero_b");

        // Start held high: second start accepted on the done cycle.
        a     = 10'd7;
        b     = 10'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{prod: PW'(7), cyc: cyc});
        sb[sb.size()-1].prod = 20'd63;
        a = 10'd100;
        b = 10'd200;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("held_done_seen", (n < 40), 1);
        sb.push_back('{prod: 20'd20000, cyc: cyc + 1});
        @(posedge clk);
        #1;
        a     = 10'd7;
        b     = 10'd9;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_busy", busy, 1);
        check("held_product_kept", product, 63);
        drain("drain_held");

        // Start pulses during ACCUM must be ignored.
        do_op(10'd21, 10'd13);
        for (int i = 0; i < 3; i++) begin
            a     = 10'($urandom_range(1, 1023));
            b     = 10'($urandom_range(1, 1023));
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(posedge clk);
            #1;
        end
        drain("drain_ignore");
        check("ignore_product", product, 273);

        // Asynchronous reset in the middle of ACCUM.
        do_op(10'd33, 10'd44);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", product, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(10'd12, 10'd12);
        drain("drain_after_rst");
        check("after_rst_product", product, 144);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/csa_mult_seq.md
Name: csa_mult_seq

Overview:
- Sequential unsigned multiplier controller built around the 20-bit carry-save adder datapath.
- Adds one shifted partial product per cycle into redundant sum/carry registers, with no carry propagation during accumulation.
- Performs a single carry-propagate resolve cycle at the end.
- Sits between the ALU issue logic and the result bus; uses a start/busy/done handshake.

Parameters:
- W, 10, operand width in bits; legal range 2..10 so the product fits the 20-bit CSA.
- PW, 2*W, product width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  W  multiplicand, unsigned; captured on accepted start
- b  input  W  multiplier, unsigned; captured on accepted start
- busy  output  1  high in ACCUM and RESOLVE
- done  output  1  one-cycle pulse when product becomes valid
- product  output  PW  result; holds until the next RESOLVE

Behaviour:
- Interface: one clock (clk), asynchronous active-low reset (rst_n).
- Reset (rst_n low, any time, including mid-operation):
  - state=IDLE; busy=0; done=0; product=0.
  - Internal sum register S=0, carry register C=0, count=0; operand registers cleared.
  - Takes effect immediately, not at a clock edge.
- States: IDLE, ACCUM, RESOLVE.
- IDLE:
  - On a clk edge with start=1: latch a into RA and b into RB, clear S and C, set count=0, go to ACCUM.
  - Otherwise stay in IDLE.
- ACCUM (exactly W cycles):
  - Partial product pp = (RA AND replicate(RB[count])) << count, zero-extended to 20 bits.
  - CSA inputs: S, (C<<1) truncated to 20 bits, and pp.
  - Register S <= CSA sum and C <= CSA cout, unshifted; the carry weight is applied on the next use.
  - count increments; when count==W-1, go to RESOLVE.
- RESOLVE (1 cycle):
  - product <= (S + (C<<1)) mod 2^PW, using a single carry-propagate add.
  - Register done <= 1, go to IDLE.
- done is high for exactly the first IDLE cycle after RESOLVE, then low.
- Latency: start accepted at edge 0 -> done and valid product visible after edge W+1, i.e. 11 cycles for W=10. busy is high for W+1 cycles.
- start while busy=1: ignored; no queuing and no effect on the operation in progress.
- start in the same cycle done=1: accepted, because the state is IDLE. product keeps the old value until the new RESOLVE.
- a and b may change freely after acceptance; only RA and RB are used.
- Arithmetic is unsigned only. The result is exact for all W-bit inputs, since PW bits are enough for (2^W-1)^2, so truncation never loses bits.
- Carry bits shifted out of bit 19 during ACCUM are provably zero for W<=10.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, then start with a=5, b=3 -> busy high 11 cycles; done pulse at cycle 11; product=15.
- a=0x3FF, b=0x3FF -> product=0xFF801 (1046529); done exactly W+1 cycles after start.
- a=0, b=0x2AB, then a=0x155, b=0 -> product=0 both times; done still pulses after full latency.
- Start held high continuously with alternating operands (7x9, 100x200) -> second start accepted on the done cycle; products 63 then 20000; no start accepted while busy.
- Start pulses during ACCUM with different a/b -> ignored; result equals the originally latched operands.
- rst_n asserted at ACCUM cycle 4, released, then start 12x12 -> busy, done and product all 0 immediately on reset; next operation gives product=144 with normal latency.
